serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator.sv | 141 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator. It scans both operands MSB-first, one DIGIT-bit
// slice per cycle, and stops at the first slice that differs. Requests and results
// use valid/ready handshakes.
module serial_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4,
  parameter int CW    = $clog2(WIDTH / DIGIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res,
  output logic             eq,
  output logic [CW-1:0]    digits
);

  localparam int ND = WIDTH / DIGIT;

  generate
    if (DIGIT < 1 || WIDTH < 2 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_magnitude_comparator: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             le_q, le_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             res_q, res_d;
  logic             eq_q, eq_d;
  logic [CW-1:0]    digits_q, digits_d;

  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;

  // The operands shift left after each equal slice, so the slice under test is always
  // the top DIGIT bits.
  assign slice_a = a_q[WIDTH-1 -: DIGIT];
  assign slice_b = b_q[WIDTH-1 -: DIGIT];

  // NOTE: every variable written here gets a default first. A path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    le_d     = le_q;
    idx_d    = idx_q;
    res_d    = res_q;
    eq_d     = eq_q;
    digits_d = digits_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d              = a;
          a_d[WIDTH-1]     = a[WIDTH-1] ^ mode[1];
          b_d              = b;
          b_d[WIDTH-1]     = b[WIDTH-1] ^ mode[1];
          le_d             = mode[0];
          idx_d            = '0;
          state_d          = SCAN;
        end
      end

      SCAN: begin
        if (slice_a != slice_b) begin
          res_d    = (slice_a < slice_b);
          eq_d     = 1'b0;
          digits_d = idx_q + CW'(1);
          state_d  = DONE;
        end else if (idx_q == CW'(ND - 1)) begin
          res_d    = le_q;
          eq_d     = 1'b1;
          digits_d = idx_q + CW'(1);
          state_d  = DONE;
        end else begin
          idx_d = idx_q + CW'(1);
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
        end
      end

      DONE: begin
        if (out_ready) begin
          res_d    = 1'b0;
          eq_d     = 1'b0;
          digits_d = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. This keeps every
  // register sampling the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      le_q     <= 1'b0;
      idx_q    <= '0;
      res_q    <= 1'b0;
      eq_q     <= 1'b0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      le_q     <= le_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      eq_q     <= eq_d;
      digits_q <= digits_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign eq        = eq_q;
  assign digits    = digits_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator. It runs directed vectors on a
// 32/4 instance and an 8/1 instance checked against a plain reference model.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 32-bit, 4-bit digit instance
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_res, m_eq;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_mode;
  logic [3:0]  m_digits;

  serial_magnitude_comparator #(.WIDTH(32), .DIGIT(4)) u_main (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .mode(m_mode),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .res(m_res), .eq(m_eq), .digits(m_digits)
  );

  // 8-bit, 1-bit digit instance
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_res, s_eq;
  logic [7:0] s_a, s_b;
  logic [1:0] s_mode;
  logic [3:0] s_digits;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .mode(s_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .res(s_res), .eq(s_eq), .digits(s_digits)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    logic        res;
    logic        eq;
    int          dig;
  } vec_t;

  // Latency from accept to out_valid equals the digit count, so one value covers both.
  task automatic run_main(input vec_t v, input string tag);
    int lat;
    check({tag, ".in_ready"}, 64'(m_in_ready), 64'd1);
    m_a = v.a; m_b = v.b; m_mode = v.mode; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(v.dig));
    check({tag, ".res"}, 64'(m_res), 64'(v.res));
    check({tag, ".eq"}, 64'(m_eq), 64'(v.eq));
    check({tag, ".digits"}, 64'(m_digits), 64'(v.dig));
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    check({tag, ".idle_ready"}, 64'({m_in_ready, m_out_valid, m_res, m_eq, m_digits}), 64'h80);
  endtask

  task automatic run_small(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode);
    int lat;
    int exp_dig;
    bit found;
    logic exp_lt, exp_eq;
    exp_eq = (a == b);
    exp_lt = mode[1] ? ($signed(a) < $signed(b)) : (a < b);
    exp_dig = 8;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && a[i] != b[i]) begin
        exp_dig = 8 - i;
        found = 1'b1;
      end
    end
    s_a = a; s_b = b; s_mode = mode; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    check("small.latency", 64'(lat), 64'(exp_dig));
    check("small.res", 64'(s_res), 64'(exp_lt | (exp_eq & mode[0])));
    check("small.eq", 64'(s_eq), 64'(exp_eq));
    check("small.digits", 64'(s_digits), 64'(exp_dig));
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check("small.idle", 64'({s_in_ready, s_out_valid}), 64'h2);
  endtask

  vec_t vecs[10] = '{
    '{32'h0000_0005, 32'h0000_0007, 2'b00, 1'b1, 1'b0, 8},
    '{32'h0000_0007, 32'h0000_0005, 2'b00, 1'b0, 1'b0, 8},
    '{32'hF000_0000, 32'h1000_0000, 2'b00, 1'b0, 1'b0, 1},
    '{32'hF000_0000, 32'h1000_0000, 2'b10, 1'b1, 1'b0, 1},
    '{32'h1234_5678, 32'h1234_5678, 2'b01, 1'b1, 1'b1, 8},
    '{32'h1234_5678, 32'h1234_5678, 2'b00, 1'b0, 1'b1, 8},
    '{32'h8000_0000, 32'h8000_0000, 2'b11, 1'b1, 1'b1, 8},
    '{32'h7FFF_FFFF, 32'h8000_0000, 2'b10, 1'b0, 1'b0, 1},
    '{32'h1234_5678, 32'h1235_5678, 2'b00, 1'b1, 1'b0, 4},
    '{32'h1234_5679, 32'h1234_5678, 2'b01, 1'b0, 1'b0, 8}
  };

  logic [7:0] corners[4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};

  initial begin
    int lat;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_a = '0; m_b = '0; m_mode = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_mode = '0;
    #12;
    check("reset.outputs", 64'({m_in_ready, m_out_valid, m_res, m_eq, m_digits}), 64'h80);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_main(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: the result holds and the pending request waits out the handshake.
    m_a = 32'h5; m_b = 32'h7; m_mode = 2'b00; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp.latency", 64'(lat), 64'd8);
    m_a = 32'hF000_0000; m_b = 32'h1000_0000; m_mode = 2'b10; m_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold", 64'({m_in_ready, m_out_valid, m_res, m_eq, m_digits}), 64'h68);
    end
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    check("bp.not_accepted", 64'({m_in_ready, m_out_valid}), 64'h2);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    check("bp.accepted", 64'(m_in_ready), 64'd0);
    lat = 0;
    while (!m_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp.new_latency", 64'(lat), 64'd1);
    check("bp.new_result", 64'({m_res, m_eq, m_digits}), 64'h21);
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;

    // Reset while slice 3 is being compared.
    m_a = 32'h5; m_b = 32'h7; m_mode = 2'b00; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.async", 64'({m_in_ready, m_out_valid, m_res, m_eq, m_digits}), 64'h80);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (m_out_valid) lat++;
    end
    check("rst.discarded", 64'(lat), 64'd0);
    run_main('{32'd3, 32'd2, 2'b00, 1'b0, 1'b0, 8}, "post_rst");

    // 8/1 instance: corner pairs across all modes, then random operands.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int m = 0; m < 4; m++)
          run_small(corners[i], corners[j], 2'(m));
    for (int n = 0; n < 150; n++)
      run_small(8'($urandom), 8'($urandom), 2'($urandom_range(3, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
